// File: rtl/hood_pkg.sv
// Shared encodings and default durations for the range-hood mode controller.
// Optional build macro HOOD_CLEAN_ABORT_EN is consumed by hood_mode_fsm.
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_STANDBY   = 3'b000,
    MODE_L1        = 3'b001,
    MODE_L2        = 3'b010,
    MODE_HURRICANE = 3'b011,
    MODE_COOLDOWN  = 3'b100,
    MODE_CLEAN     = 3'b101
  } mode_t;

  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_L1,
    REQ_L2,
    REQ_L3,
    REQ_CLEAN,
    REQ_STBY
  } req_t;

  localparam int HURRICANE_SEC_DEF = 60;
  localparam int COOLDOWN_SEC_DEF  = 60;
  localparam int CLEAN_SEC_DEF     = 180;
  localparam int CNT_W_DEF         = 8;

  // Only the highest-priority request survives; legality is judged later.
  function automatic req_t arbitrate(
    input logic s,
    input logic c,
    input logic l3,
    input logic l2,
    input logic l1
  );
    req_t r;
    r = REQ_NONE;
    if (s)       r = REQ_STBY;
    else if (c)  r = REQ_CLEAN;
    else if (l3) r = REQ_L3;
    else if (l2) r = REQ_L2;
    else if (l1) r = REQ_L1;
    return r;
  endfunction

endpackage

// File: rtl/hood_sec_countdown.sv
// Loadable seconds down-counter; saturates at zero.
// Priority: clr over load over dec; expire flags the final decrement.
module hood_sec_countdown #(
  parameter int CNT_W = 8
) (
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] remain,
  output logic             expire
);

  assign expire = dec && (remain == CNT_W'(1));

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      remain <= '0;
    end else if (clr) begin
      remain <= '0;
    end else if (load) begin
      remain <= load_val;
    end else if (dec && remain != '0) begin
      remain <= remain - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hood_mode_fsm.sv
// Range-hood operating-mode controller (1 Hz domain).
// Define HOOD_CLEAN_ABORT_EN to let standby_req abort self-clean.
module hood_mode_fsm
  import hood_pkg::*;
#(
  parameter int HURRICANE_SEC = HURRICANE_SEC_DEF,
  parameter int COOLDOWN_SEC  = COOLDOWN_SEC_DEF,
  parameter int CLEAN_SEC     = CLEAN_SEC_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk_1hz,
  input  logic             rst,
  input  logic             power_on,
  input  logic             lvl1_req,
  input  logic             lvl2_req,
  input  logic             lvl3_req,
  input  logic             standby_req,
  input  logic             clean_req,
  output logic [2:0]       mode_state,
  output logic [CNT_W-1:0] remain_sec,
  output logic             hurricane_used,
  output logic             clean_done
);

  mode_t            state;
  mode_t            next;
  req_t             req;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             dec;
  logic             clr;
  logic             expire;
  logic             set_used;
  logic             done_nxt;

  assign req = arbitrate(standby_req, clean_req,
                         lvl3_req, lvl2_req, lvl1_req);

  assign dec = power_on &&
               (state == MODE_HURRICANE ||
                state == MODE_COOLDOWN  ||
                state == MODE_CLEAN);

  hood_sec_countdown #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_1hz  (clk_1hz),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .clr      (clr),
    .remain   (remain_sec),
    .expire   (expire)
  );

  always_comb begin
    next     = state;
    load     = 1'b0;
    load_val = '0;
    clr      = 1'b0;
    set_used = 1'b0;
    done_nxt = 1'b0;
    if (!power_on) begin
      next = MODE_STANDBY;
      clr  = 1'b1;
    end else begin
      unique case (state)
        MODE_STANDBY, MODE_L1, MODE_L2: begin
          case (req)
            REQ_STBY: next = MODE_STANDBY;
            REQ_CLEAN: begin
              if (state == MODE_STANDBY) begin
                next     = MODE_CLEAN;
                load     = 1'b1;
                load_val = CNT_W'(CLEAN_SEC);
              end
            end
            REQ_L3: begin
              if (!hurricane_used) begin
                next     = MODE_HURRICANE;
                load     = 1'b1;
                load_val = CNT_W'(HURRICANE_SEC);
                set_used = 1'b1;
              end
            end
            REQ_L2:  next = MODE_L2;
            REQ_L1:  next = MODE_L1;
            default: next = state;
          endcase
        end
        MODE_HURRICANE: begin
          // A user standby wins over a same-cycle auto-drop.
          if (req == REQ_STBY) begin
            next     = MODE_COOLDOWN;
            load     = 1'b1;
            load_val = CNT_W'(COOLDOWN_SEC);
          end else if (expire) begin
            next = MODE_L2;
            clr  = 1'b1;
          end
        end
        MODE_COOLDOWN: begin
          if (expire) begin
            next = MODE_STANDBY;
            clr  = 1'b1;
          end
        end
        MODE_CLEAN: begin
`ifdef HOOD_CLEAN_ABORT_EN
          if (req == REQ_STBY) begin
            next = MODE_STANDBY;
            clr  = 1'b1;
          end else if (expire) begin
            next     = MODE_STANDBY;
            clr      = 1'b1;
            done_nxt = 1'b1;
          end
`else
          if (expire) begin
            next     = MODE_STANDBY;
            clr      = 1'b1;
            done_nxt = 1'b1;
          end
`endif
        end
        default: begin
          next = MODE_STANDBY;
          clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state          <= MODE_STANDBY;
      hurricane_used <= 1'b0;
      clean_done     <= 1'b0;
    end else begin
      state      <= next;
      clean_done <= done_nxt;
      if (!power_on)     hurricane_used <= 1'b0;
      else if (set_used) hurricane_used <= 1'b1;
    end
  end

  assign mode_state = state;

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Self-checking bench for hood_mode_fsm: vector table,
// directed timed-mode sequences and randomized model comparison.
module tb_hood_mode_fsm;

`ifdef HOOD_CLEAN_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic       clk_1hz = 1'b0;
  logic       rst = 1'b0;
  logic       power_on = 1'b0;
  logic       lvl1_req = 1'b0;
  logic       lvl2_req = 1'b0;
  logic       lvl3_req = 1'b0;
  logic       standby_req = 1'b0;
  logic       clean_req = 1'b0;
  logic [2:0] mode_state;
  logic [7:0] remain_sec;
  logic       hurricane_used;
  logic       clean_done;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode;
  int m_rem;
  bit m_used;
  bit m_done;

  typedef struct {
    bit p, s, c, l3, l2, l1;
    int mode, rem;
    bit used, done;
  } vec_t;

  vec_t tbl[19];

  hood_mode_fsm dut (
    .clk_1hz        (clk_1hz),
    .rst            (rst),
    .power_on       (power_on),
    .lvl1_req       (lvl1_req),
    .lvl2_req       (lvl2_req),
    .lvl3_req       (lvl3_req),
    .standby_req    (standby_req),
    .clean_req      (clean_req),
    .mode_state     (mode_state),
    .remain_sec     (remain_sec),
    .hurricane_used (hurricane_used),
    .clean_done     (clean_done)
  );

  always #5 clk_1hz = ~clk_1hz;

  // Mode codes: 0 stby,1 L1,2 L2,3 hurricane,4 cooldown,5 clean.
  task automatic model_step(input bit p, s, c, l3, l2, l1);
    int  pick;
    bit  user_exit;
    m_done = 1'b0;
    if (!p) begin
      m_mode = 0;
      m_rem  = 0;
      m_used = 1'b0;
      return;
    end
    pick = s ? 5 : c ? 4 : l3 ? 3 : l2 ? 2 : l1 ? 1 : 0;
    if (m_mode <= 2) begin
      if (pick == 5) m_mode = 0;
      else if (pick == 4 && m_mode == 0) begin
        m_mode = 5;
        m_rem  = 180;
      end else if (pick == 3 && !m_used) begin
        m_mode = 3;
        m_rem  = 60;
        m_used = 1'b1;
      end else if (pick == 2) m_mode = 2;
      else if (pick == 1) m_mode = 1;
    end else begin
      user_exit = (pick == 5) &&
                  (m_mode == 3 || (m_mode == 5 && ABORT));
      if (user_exit && m_mode == 3) begin
        m_mode = 4;
        m_rem  = 60;
      end else if (user_exit) begin
        m_mode = 0;
        m_rem  = 0;
      end else if (m_rem == 1) begin
        m_done = (m_mode == 5);
        m_mode = (m_mode == 3) ? 2 : 0;
        m_rem  = 0;
      end else begin
        m_rem = m_rem - 1;
      end
    end
  endtask

  task automatic cmp(input string tag, input int md, rm,
                     input bit us, dn);
    n_cmp++;
    if (int'(mode_state) != md || int'(remain_sec) != rm ||
        hurricane_used != us || clean_done != dn) begin
      n_bad++;
      $display("FAIL %s: got mode=%0d remain=%0d used=%0d done=%0d want mode=%0d remain=%0d used=%0d done=%0d",
               tag, mode_state, remain_sec, hurricane_used,
               clean_done, md, rm, us, dn);
    end
  endtask

  task automatic step(input bit p, s, c, l3, l2, l1,
                      input string tag);
    power_on    = p;
    standby_req = s;
    clean_req   = c;
    lvl3_req    = l3;
    lvl2_req    = l2;
    lvl1_req    = l1;
    @(posedge clk_1hz);
    model_step(p, s, c, l3, l2, l1);
    #1;
    cmp({tag, "/model"}, m_mode, m_rem, m_used, m_done);
    standby_req = 1'b0;
    clean_req   = 1'b0;
    lvl3_req    = 1'b0;
    lvl2_req    = 1'b0;
    lvl1_req    = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    m_mode = 0;
    m_rem  = 0;
    m_used = 1'b0;
    m_done = 1'b0;

    tbl[0]  = '{1,0,0,0,0,1, 1,  0,0,0};
    tbl[1]  = '{1,0,0,0,1,0, 2,  0,0,0};
    tbl[2]  = '{1,0,1,0,0,0, 2,  0,0,0};
    tbl[3]  = '{1,0,0,0,1,1, 2,  0,0,0};
    tbl[4]  = '{1,1,0,0,0,0, 0,  0,0,0};
    tbl[5]  = '{1,0,0,0,1,1, 2,  0,0,0};
    tbl[6]  = '{1,0,0,0,0,1, 1,  0,0,0};
    tbl[7]  = '{1,1,0,0,1,1, 0,  0,0,0};
    tbl[8]  = '{1,1,0,0,0,1, 0,  0,0,0};
    tbl[9]  = '{0,0,0,1,0,0, 0,  0,0,0};
    tbl[10] = '{1,0,1,0,0,0, 5,180,0,0};
    tbl[11] = '{1,0,0,0,0,1, 5,179,0,0};
    tbl[12] = '{0,0,0,0,0,0, 0,  0,0,0};
    tbl[13] = '{1,0,0,1,0,0, 3, 60,1,0};
    tbl[14] = '{1,0,0,0,1,0, 3, 59,1,0};
    tbl[15] = '{1,0,1,0,0,0, 3, 58,1,0};
    tbl[16] = '{1,1,0,0,0,0, 4, 60,1,0};
    tbl[17] = '{1,0,0,0,0,1, 4, 59,1,0};
    tbl[18] = '{0,0,0,0,0,0, 0,  0,0,0};

    #3;
    cmp("reset_async", 0, 0, 0, 0);
    #9 rst = 1'b1;
    idle(5, "reset_idle");
    cmp("reset_idle", 0, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].p, tbl[i].s, tbl[i].c,
           tbl[i].l3, tbl[i].l2, tbl[i].l1, "table");
      cmp($sformatf("table[%0d]", i), tbl[i].mode,
          tbl[i].rem, tbl[i].used, tbl[i].done);
    end

    step(1, 0, 0, 1, 0, 0, "hur_entry");
    cmp("hur_entry", 3, 60, 1, 0);
    for (int i = 1; i < 60; i++) begin
      step(1, 0, 0, 0, 0, 0, "hur_run");
      cmp($sformatf("hur_run[%0d]", i), 3, 60 - i, 1, 0);
    end
    step(1, 0, 0, 0, 0, 0, "hur_drop");
    cmp("hur_drop", 2, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, "hur_reuse");
    cmp("hur_reuse", 2, 0, 1, 0);

    step(0, 0, 0, 0, 0, 0, "pwr_cycle");
    step(1, 0, 0, 1, 0, 0, "cool_hur");
    idle(20, "cool_hur");
    cmp("cool_at40", 3, 40, 1, 0);
    step(1, 1, 0, 0, 0, 0, "cool_entry");
    cmp("cool_entry", 4, 60, 1, 0);
    step(1, 0, 0, 0, 0, 1, "cool_lvl1");
    cmp("cool_lvl1", 4, 59, 1, 0);
    idle(58, "cool_run");
    cmp("cool_last", 4, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, "cool_exit");
    cmp("cool_exit", 0, 0, 1, 0);

    step(1, 0, 1, 0, 0, 0, "clean_entry");
    cmp("clean_entry", 5, 180, 1, 0);
    idle(90, "clean_run");
    cmp("clean_at90", 5, 90, 1, 0);
    step(1, 1, 0, 0, 0, 0, "clean_stby");
    if (ABORT) cmp("clean_abort", 0, 0, 1, 0);
    else       cmp("clean_noabort", 5, 89, 1, 0);
    idle(ABORT ? 1 : 89, "clean_tail");
    cmp("clean_tail_done", 0, 0, 1, ABORT ? 0 : 1);
    idle(1, "clean_after");
    cmp("clean_after", 0, 0, 1, 0);

    step(1, 0, 1, 0, 0, 0, "full_clean");
    idle(179, "full_clean");
    cmp("full_clean_last", 5, 1, 1, 0);
    step(1, 0, 0, 0, 0, 0, "full_clean_exit");
    cmp("full_clean_exit", 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, "full_clean_pulse");
    cmp("full_clean_pulse", 0, 0, 1, 0);

    step(0, 0, 0, 0, 0, 0, "poff_prep");
    step(1, 0, 0, 1, 0, 0, "poff_hur");
    idle(5, "poff_hur");
    step(0, 0, 0, 0, 0, 0, "poff");
    cmp("poff", 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, "poff_reenter");
    cmp("poff_reenter", 3, 60, 1, 0);
    step(1, 1, 0, 0, 0, 0, "prio_to_cool");
    step(0, 0, 0, 0, 0, 0, "prio_off");
    step(1, 0, 0, 0, 1, 1, "prio_l12");
    cmp("prio_l12", 2, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
